mem_boot_loader: RTL
====================

// Module: mem_boot_loader
// PURPOSE
// - Streams a program image from a host into CPU instruction/data memory; holds CPU in reset until load completes.
// - Replaces hand-driven write_instruction/write_data/address/inst_data sequencing: host sends header-framed segments over valid/ready.
// - Drives the CPU's existing load ports directly.
// - Generalised in word width, address width and segment length; adds wrap-around, multi-segment loads and reload-from-run.
// PARAMETERS
// - DATA_W  32  memory word / host word width
// - ADDR_W  10  memory address width (both memories)
// - CNT_W   10  header word-count field width; segment length 1..2**CNT_W
// - Legal only when ADDR_W+CNT_W <= DATA_W-2 (elaboration-time check)
// PORTS
// - clk                in   1       clock, rising edge
// - rst                in   1       reset: one clock, asynchronous, active-high
// - host_valid         in   1       host word valid
// - host_ready         out  1       loader accepts word; beat = valid&&ready
// - host_data          in   DATA_W  header / payload / checksum word
// - reload             in   1       pulse: return from RUN/ERROR to load mode
// - write_instruction  out  1       1-cycle instruction-memory write strobe
// - write_data         out  1       1-cycle data-memory write strobe
// - address            out  ADDR_W  write address
// - inst_data          out  DATA_W  write word
// - cpu_rst            out  1       CPU reset; 1 while loading
// - busy               out  1       state is PAYLOAD or CKSUM
// - error              out  1       checksum failure (CHECKSUM_EN only, else 0)
// BEHAVIOUR
// - Reset values: state=HDR, cpu_rst=1, host_ready=1, write_*=0, address=0, inst_data=0, busy=0, error=0.
// - Header fields: [DATA_W-1] target (0 instr, 1 data); [DATA_W-2] go; [ADDR_W+CNT_W-1:ADDR_W] count-1; [ADDR_W-1:0] start.
// - Header bits not in these fields are ignored.
// - FSM states: HDR, PAYLOAD, CKSUM, RUN, ERROR.
//   - HDR: ready=1; beat latches header, loads address counter=start, remaining=count-1; -> PAYLOAD.
//   - PAYLOAD: ready=1; each beat registers one write (address, inst_data, strobe of the latched target).
//     Strobe appears the cycle after the beat, for exactly one cycle.
//     Address +1 per beat, modulo 2**ADDR_W (0x3FF -> 0x000).
//     On the last beat -> CKSUM if CHECKSUM_EN; else -> RUN if go, HDR if !go.
//   - RUN: ready=0; cpu_rst=0 from the cycle after the final write strobe cycle (strictly after the last write).
//     reload -> cpu_rst=1 next cycle, state HDR.
//   - ERROR: ready=0; cpu_rst=1; error=1; reload -> HDR, clears error.
// - Back-to-back beats are accepted every cycle: throughput 1 word/clk, write latency 1 clk.
// - reload in HDR/PAYLOAD/CKSUM is ignored.
// - Ready drops in RUN and ERROR; a valid word held there is not consumed.
// - rst at any point, including mid-segment: immediate return to reset values.
//   Partially written memory is left as-is; a pending strobe is cancelled.
// CONFIGURATION
// - Macro BOOT_LOADER_CHECKSUM_EN defined:
//   - Each segment ends with one checksum word (CKSUM state, ready=1).
//   - Expected value = XOR of header and all payload words of that segment.
//   - Match -> RUN if go, else HDR.
//   - Mismatch -> ERROR, cpu_rst stays 1.
// - Macro undefined: no CKSUM state, no trailing word, error tied 0.
// STRUCTURE
// - Package boot_loader_pkg: state enum; header field offset localparams (TGT_BIT, GO_BIT, CNT_LSB, ADDR_LSB) derived from DATA_W/ADDR_W/CNT_W.
// - Sub-module boot_cksum_acc: XOR accumulator, clear on header beat. Instantiated only under BOOT_LOADER_CHECKSUM_EN.
// - Everything else is flat: FSM, address counter, remaining counter, output registers.
// TESTING
// - Reset: rst=1 -> cpu_rst=1, host_ready=1, write_*=0, address=0; same on async assert mid-cycle.
// - 9-word instruction program:
//   - header 0x0000_2000 then 9 words -> write_instruction pulses at addresses 0..8, data matches, state returns to HDR.
//   - Then header 0xC000_0006 + word 7 -> write_data at address 6 with data 7.
//   - cpu_rst falls the cycle after that strobe.
// - Wrap: header 0x8000_0FFE + 4 words -> data writes at 0x3FE, 0x3FF, 0x000, 0x001.
// - Backpressure: host_valid toggled 1/0 randomly -> one strobe per accepted beat, none for idle cycles; in RUN, host_ready=0 and held word is not consumed.
// - Reload: in RUN, pulse reload -> cpu_rst=1 next cycle, new 1-word segment at 0x005 loads correctly.
// - CHECKSUM_EN: correct XOR trailer -> RUN; corrupted trailer -> error=1, cpu_rst=1, ready=0; reload clears error.

Source files
------------

// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the memory boot loader: FSM state encoding,
// default widths and header field offsets.
package boot_loader_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_CNT_W  = 10;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_PAYLOAD,
      ST_CKSUM,
      ST_RUN,
      ST_ERROR
   } state_t;

   // Header field positions as functions of the configured widths
   function automatic int tgt_bit(input int data_w);
      return data_w - 1;
   endfunction

   function automatic int go_bit(input int data_w);
      return data_w - 2;
   endfunction

   function automatic int cnt_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int addr_lsb();
      return 0;
   endfunction

   // Offsets for the default configuration
   localparam int TGT_BIT  = tgt_bit(DEF_DATA_W);
   localparam int GO_BIT   = go_bit(DEF_DATA_W);
   localparam int CNT_LSB  = cnt_lsb(DEF_ADDR_W);
   localparam int ADDR_LSB = addr_lsb();

endpackage

// File: rtl/mem_boot_loader_if.sv
// Host stream plus CPU memory load port of the boot loader.
// slave: loader side; master: host / memory side.
interface mem_boot_loader_if
   import boot_loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              host_valid;
   logic              host_ready;
   logic [DATA_W-1:0] host_data;
   logic              write_instruction;
   logic              write_data;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] inst_data;

   modport master (
      output host_valid, host_data,
      input  host_ready, write_instruction, write_data, address, inst_data
   );

   modport slave (
      input  host_valid, host_data,
      output host_ready, write_instruction, write_data, address, inst_data
   );
endinterface

// File: rtl/mem_boot_loader_cksum_acc.sv
// Running XOR of a segment: restarts with the header word, folds in
// every payload word.
module boot_cksum_acc #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hdr_beat,
   input  logic              data_beat,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] sum
);
   // Accumulator: header restarts the sum, payload words fold in
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            sum <= '0;
      else if (hdr_beat)  sum <= data;
      else if (data_beat) sum <= sum ^ data;
   end
endmodule

// File: rtl/mem_boot_loader.sv
// Streams header-framed segments from a host into CPU instruction/data
// memory and holds the CPU in reset until a segment with 'go' completes.
// Optional feature: define BOOT_LOADER_CHECKSUM_EN for an XOR trailer
// word per segment and an ERROR state on mismatch.
module mem_boot_loader
   import boot_loader_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_boot_loader_if.slave     host,
   input  logic                 reload,
   output logic                 cpu_rst,
   output logic                 busy,
   output logic                 error
);
   localparam int TGT_POS  = tgt_bit(DATA_W);
   localparam int GO_POS   = go_bit(DATA_W);
   localparam int CNT_POS  = cnt_lsb(ADDR_W);
   localparam int ADDR_POS = addr_lsb();

   if (ADDR_W + CNT_W > DATA_W - 2) begin : g_bad_widths
      $error("mem_boot_loader: ADDR_W+CNT_W must not exceed DATA_W-2");
   end

   state_t            state_q, state_d;
   logic              tgt_q, go_q;
   logic [ADDR_W-1:0] addr_cnt_q;
   logic [CNT_W-1:0]  rem_q;
   logic              hdr_beat, pay_beat, last_beat;

   assign hdr_beat  = host.host_valid && (state_q == ST_HDR);
   assign pay_beat  = host.host_valid && (state_q == ST_PAYLOAD);
   assign last_beat = (rem_q == '0);

`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum;

   boot_cksum_acc #(.DATA_W(DATA_W)) u_cksum (
      .clk       (clk),
      .rst       (rst),
      .hdr_beat  (hdr_beat),
      .data_beat (pay_beat),
      .data      (host.host_data),
      .sum       (sum)
   );
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_HDR;
      else     state_q <= state_d;
   end

   // Next-state logic plus the state-decoded handshake/status outputs
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      state_d         = state_q;
      host.host_ready = 1'b0;
      busy            = 1'b0;
      error           = 1'b0;
      unique case (state_q)
         ST_HDR: begin
            host.host_ready = 1'b1;
            if (host.host_valid) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            host.host_ready = 1'b1;
            busy            = 1'b1;
            if (host.host_valid && last_beat) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
               state_d = ST_CKSUM;
`else
               state_d = go_q ? ST_RUN : ST_HDR;
`endif
            end
         end
         ST_CKSUM: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            host.host_ready = 1'b1;
            busy            = 1'b1;
            if (host.host_valid) begin
               if (host.host_data == sum) state_d = go_q ? ST_RUN : ST_HDR;
               else                       state_d = ST_ERROR;
            end
`else
            state_d = ST_HDR;
`endif
         end
         ST_RUN: begin
            if (reload) state_d = ST_HDR;
         end
         ST_ERROR: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            error = 1'b1;
`endif
            if (reload) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
   end

   // Header latch, address/remaining counters, registered write port and CPU reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q                  <= 1'b0;
         go_q                   <= 1'b0;
         addr_cnt_q             <= '0;
         rem_q                  <= '0;
         host.write_instruction <= 1'b0;
         host.write_data        <= 1'b0;
         host.address           <= '0;
         host.inst_data         <= '0;
         cpu_rst                <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         host.write_instruction <= 1'b0;
         host.write_data        <= 1'b0;
         if (hdr_beat) begin
            tgt_q      <= host.host_data[TGT_POS];
            go_q       <= host.host_data[GO_POS];
            addr_cnt_q <= host.host_data[ADDR_POS +: ADDR_W];
            rem_q      <= host.host_data[CNT_POS +: CNT_W];
         end
         if (pay_beat) begin
            host.address           <= addr_cnt_q;
            host.inst_data         <= host.host_data;
            host.write_instruction <= !tgt_q;
            host.write_data        <= tgt_q;
            addr_cnt_q             <= addr_cnt_q + ADDR_W'(1);
            rem_q                  <= rem_q - CNT_W'(1);
         end
         // RUN is entered on the last write edge, so the release lands one cycle after the strobe
         cpu_rst <= !((state_q == ST_RUN) && !reload);
      end
   end
endmodule
